// File: rtl/if_mem_responder.sv
// if_mem_responder: read-only instruction cache between the IF stage and
// physical memory. 8 lines x 16 bytes, direct-mapped, two-state fill FSM.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   if_memaddr          fetch byte address
//   if_memread          fetch request, held until if_mem_resp
//   if_mem_byte_enable  unused, a full word is always returned
//   if_mem_resp         fetch done, if_mem_rdata valid this cycle
//   if_mem_rdata        instruction word, zero when not responding
//   pmem_address        line-aligned fill address, zero outside FILL
//   pmem_read           line fill request, held until pmem_resp
//   pmem_resp           fill line valid this cycle
//   pmem_rdata          fill line, word k at bits [16k+15:16k]
module if_mem_responder (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  if_memaddr,
  input  logic         if_memread,
  input  logic [1:0]   if_mem_byte_enable,
  output logic         if_mem_resp,
  output logic [15:0]  if_mem_rdata,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state;

  logic [7:0]   valid_q;
  logic [8:0]   tag_q  [8];
  logic [127:0] data_q [8];

  // Line being filled, frozen at the miss so a
  // redirect cannot retarget an in-flight fill.
  logic [8:0] miss_tag;
  logic [2:0] miss_idx;

  logic [8:0]   req_tag;
  logic [2:0]   req_idx;
  logic [2:0]   req_off;
  logic [127:0] req_line;
  logic [15:0]  req_word;
  logic         tag_eq;
  logic         hit;
  logic         fill_done;
  logic         unused_bits;

  assign req_tag = if_memaddr[15:7];
  assign req_idx = if_memaddr[6:4];
  assign req_off = if_memaddr[3:1];

  assign unused_bits = ^{if_mem_byte_enable,
                         if_memaddr[0]};

  assign req_line = data_q[req_idx];
  assign req_word = req_line[{req_off, 4'b0000} +: 16];
  assign tag_eq   = (tag_q[req_idx] == req_tag);

  // Hits are only served from IDLE, so a response
  // can never overlap an outstanding fill.
  assign hit = !rst
            && (state == IDLE)
            && if_memread
            && valid_q[req_idx]
            && tag_eq;

  assign fill_done = (state == FILL) && pmem_resp;

  assign if_mem_resp  = hit;
  assign if_mem_rdata = hit ? req_word : 16'h0000;

  always_comb begin
    pmem_read    = 1'b0;
    pmem_address = 16'h0000;
    if (state == FILL) begin
      pmem_read    = 1'b1;
      pmem_address = {miss_tag, miss_idx, 4'b0000};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 8'h00;
      miss_tag <= 9'h000;
      miss_idx <= 3'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_memread && !hit) begin
            state    <= FILL;
            miss_tag <= req_tag;
            miss_idx <= req_idx;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state             <= IDLE;
            valid_q[miss_idx] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Tag/data need no reset; valid_q gates them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_if_mem_responder.sv
// tb_if_mem_responder: directed scenarios for if_mem_responder.
// Inputs change 1 time unit after posedge, outputs sampled 1 unit later.
module tb_if_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  if_memaddr;
  logic         if_memread;
  logic [1:0]   if_mem_byte_enable;
  logic         if_mem_resp;
  logic [15:0]  if_mem_rdata;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int pass_cnt = 0;
  int total    = 0;

  logic [127:0] line_a;

  if_mem_responder dut (
    .clk                (clk),
    .rst                (rst),
    .if_memaddr         (if_memaddr),
    .if_memread         (if_memread),
    .if_mem_byte_enable (if_mem_byte_enable),
    .if_mem_resp        (if_mem_resp),
    .if_mem_rdata       (if_mem_rdata),
    .pmem_address       (pmem_address),
    .pmem_read          (pmem_read),
    .pmem_resp          (pmem_resp),
    .pmem_rdata         (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    logic [15:0]  w;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      w = base + 16'(k);
      l[16*k +: 16] = w;
    end
    return l;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    if_memread = 1'b1;
    if_memaddr = 16'h0042;
    if_mem_byte_enable = 2'b11;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'h7700);
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL reset_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    total++; if (if_mem_rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", if_mem_rdata); else pass_cnt++;
    total++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read: got %b want 0", pmem_read); else pass_cnt++;
    total++; if (pmem_address !== 16'h0000) $display("FAIL reset_pmem_addr: got %h want 0000", pmem_address); else pass_cnt++;
    tick;
    tick;
    total++; if (pmem_read !== 1'b0) $display("FAIL reset_hold_pmem_read: got %b want 0", pmem_read); else pass_cnt++;
    if_memread = 1'b0;
    pmem_resp = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_cold_miss;
    line_a = mk_line(16'hA000);
    line_a[31:16] = 16'h1234;
    if_memaddr = 16'h0042;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL cold_miss_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        pmem_resp = 1'b1;
        pmem_rdata = line_a;
      end
      #1;
      total++; if (pmem_read !== 1'b1) $display("FAIL cold_fill_read[%0d]: got %b want 1", i, pmem_read); else pass_cnt++;
      total++; if (pmem_address !== 16'h0040) $display("FAIL cold_fill_addr[%0d]: got %h want 0040", i, pmem_address); else pass_cnt++;
      total++; if (if_mem_resp !== 1'b0) $display("FAIL cold_fill_resp[%0d]: got %b want 0", i, if_mem_resp); else pass_cnt++;
      total++; if (if_mem_rdata !== 16'h0000) $display("FAIL cold_fill_rdata[%0d]: got %h want 0000", i, if_mem_rdata); else pass_cnt++;
      tick;
    end
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    total++; if (if_mem_resp !== 1'b1) $display("FAIL cold_done_resp: got %b want 1", if_mem_resp); else pass_cnt++;
    total++; if (if_mem_rdata !== 16'h1234) $display("FAIL cold_done_rdata: got %h want 1234", if_mem_rdata); else pass_cnt++;
    total++; if (pmem_read !== 1'b0) $display("FAIL cold_done_pmem_read: got %b want 0", pmem_read); else pass_cnt++;
    total++; if (pmem_address !== 16'h0000) $display("FAIL cold_done_pmem_addr: got %h want 0000", pmem_address); else pass_cnt++;
    tick;
  endtask

  task automatic test_hit;
    if_memaddr = 16'h004E;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b1) $display("FAIL hit_w7_resp: got %b want 1", if_mem_resp); else pass_cnt++;
    total++; if (if_mem_rdata !== 16'hA007) $display("FAIL hit_w7_rdata: got %h want a007", if_mem_rdata); else pass_cnt++;
    total++; if (pmem_read !== 1'b0) $display("FAIL hit_pmem_read: got %b want 0", pmem_read); else pass_cnt++;
    tick;
    if_memaddr = 16'h0043;
    if_mem_byte_enable = 2'b01;
    #1;
    total++; if (if_mem_rdata !== 16'h1234) $display("FAIL hit_odd_byte_rdata: got %h want 1234", if_mem_rdata); else pass_cnt++;
    tick;
    if_memaddr = 16'h0048;
    if_mem_byte_enable = 2'b10;
    #1;
    total++; if (if_mem_rdata !== 16'hA004) $display("FAIL hit_w4_rdata: got %h want a004", if_mem_rdata); else pass_cnt++;
    total++; if (pmem_read !== 1'b0) $display("FAIL hit_w4_pmem_read: got %b want 0", pmem_read); else pass_cnt++;
    if_mem_byte_enable = 2'b11;
    tick;
    if_memread = 1'b0;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL hit_noreq_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
  endtask

  task automatic test_conflict;
    if_memaddr = 16'h00C0;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL conflict_miss_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'hD000);
    #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL conflict_fill_read: got %b want 1", pmem_read); else pass_cnt++;
    total++; if (pmem_address !== 16'h00C0) $display("FAIL conflict_fill_addr: got %h want 00c0", pmem_address); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    #1;
    total++; if (if_mem_resp !== 1'b1) $display("FAIL conflict_hit_resp: got %b want 1", if_mem_resp); else pass_cnt++;
    total++; if (if_mem_rdata !== 16'hD000) $display("FAIL conflict_hit_rdata: got %h want d000", if_mem_rdata); else pass_cnt++;
    tick;
    if_memaddr = 16'h0040;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL evicted_miss_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = line_a;
    #1;
    total++; if (pmem_address !== 16'h0040) $display("FAIL evicted_fill_addr: got %h want 0040", pmem_address); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    if_memaddr = 16'h0042;
    #1;
    total++; if (if_mem_rdata !== 16'h1234) $display("FAIL refill_rdata: got %h want 1234", if_mem_rdata); else pass_cnt++;
    tick;
    if_memread = 1'b0;
    tick;
  endtask

  task automatic test_redirect;
    if_memaddr = 16'h0100;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL redir_miss_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    if_memaddr = 16'h0200;
    #1;
    total++; if (pmem_address !== 16'h0100) $display("FAIL redir_addr_c1: got %h want 0100", pmem_address); else pass_cnt++;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL redir_resp_c1: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'hB000);
    #1;
    total++; if (pmem_address !== 16'h0100) $display("FAIL redir_addr_c2: got %h want 0100", pmem_address); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    if_memaddr = 16'h0100;
    #1;
    total++; if (if_mem_rdata !== 16'hB000) $display("FAIL redir_orig_rdata: got %h want b000", if_mem_rdata); else pass_cnt++;
    if_memaddr = 16'h0200;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL redir_new_miss: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'hC000);
    #1;
    total++; if (pmem_address !== 16'h0200) $display("FAIL redir_fill2_addr: got %h want 0200", pmem_address); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    #1;
    total++; if (if_mem_rdata !== 16'hC000) $display("FAIL redir_fill2_rdata: got %h want c000", if_mem_rdata); else pass_cnt++;
    tick;
    if_memread = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_fill;
    if_memaddr = 16'h0300;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL rstfill_miss_resp: got %b want 0", if_mem_resp); else pass_cnt++;
    tick;
    #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL rstfill_read: got %b want 1", pmem_read); else pass_cnt++;
    rst = 1'b1;
    if_memread = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rstfill_async_read: got %b want 0", pmem_read); else pass_cnt++;
    total++; if (pmem_address !== 16'h0000) $display("FAIL rstfill_async_addr: got %h want 0000", pmem_address); else pass_cnt++;
    tick;
    rst = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'hE000);
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rstfill_stray_read: got %b want 0", pmem_read); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL rstfill_remiss: got %b want 0", if_mem_resp); else pass_cnt++;
    if_memaddr = 16'h0200;
    #1;
    total++; if (if_mem_resp !== 1'b0) $display("FAIL rstfill_cleared: got %b want 0", if_mem_resp); else pass_cnt++;
    if_memaddr = 16'h0300;
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = mk_line(16'hF000);
    #1;
    total++; if (pmem_address !== 16'h0300) $display("FAIL rstfill_refill_addr: got %h want 0300", pmem_address); else pass_cnt++;
    tick;
    pmem_resp = 1'b0;
    if_memaddr = 16'h0302;
    #1;
    total++; if (if_mem_rdata !== 16'hF001) $display("FAIL rstfill_refill_rdata: got %h want f001", if_mem_rdata); else pass_cnt++;
    tick;
    if_memread = 1'b0;
    tick;
  endtask

  task automatic test_idle_stray;
    if_memaddr = 16'h0302;
    if_memread = 1'b0;
    pmem_rdata = {8{16'h5555}};
    for (int i = 0; i < 3; i++) begin
      pmem_resp = (i != 1);
      #1;
      total++; if (if_mem_resp !== 1'b0) $display("FAIL stray_resp[%0d]: got %b want 0", i, if_mem_resp); else pass_cnt++;
      total++; if (pmem_read !== 1'b0) $display("FAIL stray_pmem_read[%0d]: got %b want 0", i, pmem_read); else pass_cnt++;
      total++; if (if_mem_rdata !== 16'h0000) $display("FAIL stray_rdata[%0d]: got %h want 0000", i, if_mem_rdata); else pass_cnt++;
      tick;
    end
    pmem_resp = 1'b0;
    if_memread = 1'b1;
    #1;
    total++; if (if_mem_resp !== 1'b1) $display("FAIL stray_after_resp: got %b want 1", if_mem_resp); else pass_cnt++;
    total++; if (if_mem_rdata !== 16'hF001) $display("FAIL stray_after_rdata: got %h want f001", if_mem_rdata); else pass_cnt++;
    tick;
    if_memread = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    if_memaddr = 16'h0000;
    if_memread = 1'b0;
    if_mem_byte_enable = 2'b11;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    line_a = '0;
    tick;
    test_reset;
    test_cold_miss;
    test_hit;
    test_conflict;
    test_redirect;
    test_reset_mid_fill;
    test_idle_stray;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
